// File: rtl/lbike_input_conditioner_if.sv
// Button and pulse bundle between the raw board inputs and the lightbike FSM.
// The master drives the buttons and TurnEnable, and the slave returns the conditioned pulses.
interface lbike_input_conditioner_if;
  logic BtnP1L;
  logic BtnP1R;
  logic BtnP2L;
  logic BtnP2R;
  logic BtnStart;
  logic BtnAck;
  logic TurnEnable;
  logic P1L;
  logic P1R;
  logic P2L;
  logic P2R;
  logic Start;
  logic Ack;

  modport master (
    output BtnP1L, BtnP1R, BtnP2L, BtnP2R, BtnStart, BtnAck, TurnEnable,
    input  P1L, P1R, P2L, P2R, Start, Ack
  );

  modport slave (
    input  BtnP1L, BtnP1R, BtnP2L, BtnP2R, BtnStart, BtnAck, TurnEnable,
    output P1L, P1R, P2L, P2R, Start, Ack
  );
endinterface

// File: rtl/lbike_input_conditioner.sv
// Synchronises and debounces six pushbuttons into single-cycle pulses, resolves
// same-player turn conflicts, and gates turns with TurnEnable.
module lbike_input_conditioner #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 19
) (
  input  logic                        Clk,
  input  logic                        Reset,
  lbike_input_conditioner_if.slave    io_bus
);

  localparam int unsigned N_CH = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HELD, ST_REL} state_t;

  // Channel order: 0 P1L, 1 P1R, 2 P2L, 3 P2R, 4 Start, 5 Ack
  logic [N_CH-1:0]  w_btn;
  logic [N_CH-1:0]  r_s1;
  logic [N_CH-1:0]  r_s2;
  state_t           r_state    [N_CH];
  state_t           w_state_nxt[N_CH];
  logic [CNT_W-1:0] r_cnt      [N_CH];
  logic [CNT_W-1:0] w_cnt_nxt  [N_CH];
  logic [N_CH-1:0]  w_raw;
  logic [N_CH-1:0]  w_out_nxt;
  logic [N_CH-1:0]  r_out;

  assign w_btn = {io_bus.BtnAck, io_bus.BtnStart, io_bus.BtnP2R,
                  io_bus.BtnP2L, io_bus.BtnP1R, io_bus.BtnP1L};

  // State, counter and synchroniser registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Next state; the counter clears on every transition and stops at CNT_MAX
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = '0;
      case (r_state[i])
        ST_IDLE: begin
          if (r_s2[i]) w_state_nxt[i] = ST_ARM;
        end
        ST_ARM: begin
          if (r_cnt[i] == CNT_MAX)  w_state_nxt[i] = ST_HELD;
          else if (!r_s2[i])        w_state_nxt[i] = ST_IDLE;
          else                      w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
        end
        ST_HELD: begin
          if (!r_s2[i]) w_state_nxt[i] = ST_REL;
        end
        ST_REL: begin
          if (r_cnt[i] == CNT_MAX)  w_state_nxt[i] = ST_IDLE;
          else if (r_s2[i])         w_state_nxt[i] = ST_HELD;
          else                      w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
        end
        default: w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // Raw press pulse: the cycle ARM completes its stable-high count
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_raw[i] = (r_state[i] == ST_ARM) && (r_cnt[i] == CNT_MAX);
    end
  end

  // Same-player L+R cancels both; turns are dropped when not enabled
  always_comb begin
    w_out_nxt    = '0;
    w_out_nxt[0] = w_raw[0] & ~w_raw[1] & io_bus.TurnEnable;
    w_out_nxt[1] = w_raw[1] & ~w_raw[0] & io_bus.TurnEnable;
    w_out_nxt[2] = w_raw[2] & ~w_raw[3] & io_bus.TurnEnable;
    w_out_nxt[3] = w_raw[3] & ~w_raw[2] & io_bus.TurnEnable;
    w_out_nxt[4] = w_raw[4];
    w_out_nxt[5] = w_raw[5];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_out <= '0;
    else       r_out <= w_out_nxt;
  end

  assign io_bus.P1L   = r_out[0];
  assign io_bus.P1R   = r_out[1];
  assign io_bus.P2L   = r_out[2];
  assign io_bus.P2R   = r_out[3];
  assign io_bus.Start = r_out[4];
  assign io_bus.Ack   = r_out[5];

endmodule

// File: tb/tb_lbike_input_conditioner.sv
// Directed bench for lbike_input_conditioner with DB_CYCLES=4, CNT_W=3.
// Edge 0 is the first rising edge after an input change; with these parameters a press pulses in the cycle after edge 7.
module tb_lbike_input_conditioner;

  localparam logic [5:0] M_P1L   = 6'b000001;
  localparam logic [5:0] M_P1R   = 6'b000010;
  localparam logic [5:0] M_P2L   = 6'b000100;
  localparam logic [5:0] M_P2R   = 6'b001000;
  localparam logic [5:0] M_START = 6'b010000;
  localparam logic [5:0] M_ACK   = 6'b100000;
  localparam logic [5:0] M_NONE  = 6'b000000;

  logic Clk;
  logic Reset;
  int   n_tests;
  int   n_fail;

  lbike_input_conditioner_if bus ();

  lbike_input_conditioner #(
    .DB_CYCLES (4),
    .CNT_W     (3)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .io_bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [5:0] outs();
    return {bus.Ack, bus.Start, bus.P2R, bus.P2L, bus.P1R, bus.P1L};
  endfunction

  task automatic check(input logic [5:0] exp, input string tag, input int k);
    logic [5:0] obs;
    obs = outs();
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
      end
  endtask

  // One rising edge, then sample 1 time unit later
  task automatic step(input logic [5:0] exp, input string tag, input int k);
    @(posedge Clk);
    #1;
    check(exp, tag, k);
  endtask

  // n edges; pulse mask expected only after edge pulse_at (-1 = never)
  task automatic run(input int n, input int pulse_at, input logic [5:0] mask, input string tag);
    for (int k = 0; k < n; k++) begin
      step((k == pulse_at) ? mask : M_NONE, tag, k);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset   = 1'b1;
    bus.BtnP1L = 1'b0; bus.BtnP1R = 1'b0; bus.BtnP2L = 1'b0;
    bus.BtnP2R = 1'b0; bus.BtnStart = 1'b0; bus.BtnAck = 1'b0;
    bus.TurnEnable = 1'b1;

    #2;
    check(M_NONE, "reset_async", 0);
    step(M_NONE, "reset_held", 0);
    step(M_NONE, "reset_held", 1);
    Reset = 1'b0;
    run(3, -1, M_NONE, "post_reset");

    // Clean press held 20 cycles
    bus.BtnP1L = 1'b1;
    run(20, 7, M_P1L, "t1_press");
    bus.BtnP1L = 1'b0;
    run(10, -1, M_NONE, "t1_release");

    // Bouncing start, then stable
    bus.BtnStart = 1'b1; step(M_NONE, "t2_bounce", 0);
    bus.BtnStart = 1'b0; step(M_NONE, "t2_bounce", 1);
    bus.BtnStart = 1'b1; step(M_NONE, "t2_bounce", 2);
    bus.BtnStart = 1'b0; step(M_NONE, "t2_bounce", 3);
    bus.BtnStart = 1'b1;
    run(12, 7, M_START, "t2_start");
    bus.BtnStart = 1'b0;
    run(10, -1, M_NONE, "t2_release");

    // Same-player conflict cancels both
    bus.BtnP2L = 1'b1; bus.BtnP2R = 1'b1;
    run(15, -1, M_NONE, "t3_p2_conflict");
    bus.BtnP2L = 1'b0; bus.BtnP2R = 1'b0;
    run(10, -1, M_NONE, "t3_release");

    // Different players pass together
    bus.BtnP1L = 1'b1; bus.BtnP2R = 1'b1;
    run(12, 7, M_P1L | M_P2R, "t3_p1l_p2r");
    bus.BtnP1L = 1'b0; bus.BtnP2R = 1'b0;
    run(10, -1, M_NONE, "t3_release2");

    // TurnEnable low drops the pulse; no late fire when it rises
    bus.TurnEnable = 1'b0;
    bus.BtnP1R = 1'b1;
    run(10, -1, M_NONE, "t4_gated");
    bus.TurnEnable = 1'b1;
    run(10, -1, M_NONE, "t4_enable_rise");
    bus.BtnP1R = 1'b0;
    run(6, -1, M_NONE, "t4_release");
    bus.BtnP1R = 1'b1;
    run(12, 7, M_P1R, "t4_repress");
    bus.BtnP1R = 1'b0;
    run(10, -1, M_NONE, "t4_release2");

    // Reset mid-press restarts the press
    bus.BtnAck = 1'b1;
    run(6, -1, M_NONE, "t5_before_reset");
    Reset = 1'b1;
    step(M_NONE, "t5_in_reset", 6);
    step(M_NONE, "t5_in_reset", 7);
    Reset = 1'b0;
    run(12, 7, M_ACK, "t5_after_reset");
    bus.BtnAck = 1'b0;
    run(10, -1, M_NONE, "t5_release");

    // Short dropout while held does not re-fire
    bus.BtnP1L = 1'b1;
    run(12, 7, M_P1L, "t6_press");
    bus.BtnP1L = 1'b0;
    step(M_NONE, "t6_dropout", 0);
    bus.BtnP1L = 1'b1;
    run(15, -1, M_NONE, "t6_rehigh");
    bus.BtnP1L = 1'b0;
    run(10, -1, M_NONE, "t6_release");

    // Start and Ack ignore TurnEnable; a gated turn still drops
    bus.TurnEnable = 1'b0;
    bus.BtnStart = 1'b1; bus.BtnAck = 1'b1; bus.BtnP2L = 1'b1;
    run(12, 7, M_START | M_ACK, "t7_start_ack");
    bus.BtnStart = 1'b0; bus.BtnAck = 1'b0; bus.BtnP2L = 1'b0;
    run(10, -1, M_NONE, "t7_release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
